mp_add_sequencer: RTL and testbench
===================================

Name: mp_add_sequencer

Overview:
Multi-precision add controller for the team's 16-bit Sklansky adder. It sequences one external combinational 16-bit adder over WORDS limbs, LSB limb first, and chains the carry through a register. This gives a WORDS*16-bit sum. It sits between a start/done command interface and one shared 16-bit adder instance.

Parameters:
W, 16, limb width; must match the external adder width.
WORDS, 4, number of limbs; operand width is W*WORDS; legal range 2..16.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-high.
start  input  1  command strobe; sampled only in IDLE.
a  input  W*WORDS  operand A; captured on an accepted start.
b  input  W*WORDS  operand B; captured on an accepted start.
cin  input  1  carry-in to limb 0; captured on an accepted start.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse; sum and cout are valid from this cycle on.
sum  output  W*WORDS  result register; held until the next accepted start.
cout  output  1  carry out of the top limb; held like sum.
ovf  output  1  signed overflow (see Optional Feature).
add_a  output  W  limb of A presented to the adder.
add_b  output  W  limb of B presented to the adder.
add_cin  output  1  carry presented to the adder.
add_sum  input  W  adder sum; combinational response to add_a/add_b/add_cin.
add_cout  input  1  adder carry-out.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE, idx=0, carry register=0.
  - busy=0, done=0, sum=0, cout=0, ovf=0.
  - Reset overrides start and aborts any RUN in progress. Partial results are discarded and sum is cleared to 0.
- States: IDLE, RUN.
  - IDLE→RUN when start=1. At that edge: latch a, b, cin; idx=0; busy←1.
  - RUN: each edge writes add_sum into sum limb idx, carry←add_cout, idx←idx+1.
  - At idx=WORDS-1: write the final limb, cout←add_cout, busy←0, done←1, state←IDLE.
  - done is high only in the cycle after that edge.
- Adder drive (combinational from state, idx and latched operands):
  - RUN: add_a=A limb idx, add_b=B limb idx, add_cin = latched cin when idx=0, else the carry register.
  - IDLE: add_a=0, add_b=0, add_cin=0.
- Latency: with edge 0 sampling start, limbs are written at edges 1..WORDS.
  - done=1 and busy=0 during the cycle after edge WORDS.
  - Throughput is one operation per WORDS+1 cycles when start is held high.
- start while busy=1: ignored; no queuing and no effect on the operation in flight.
- start during the done cycle: accepted, since the state is IDLE. busy rises on the next edge, and the previous sum/cout stay visible until overwritten limb by limb.
- Changes to a, b or cin after acceptance have no effect on the operation in flight.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(W*WORDS+1); no saturation.
- idx width is clog2(WORDS). The counter never wraps past WORDS-1.

Optional Feature:
Macro MP_ADD_OVF_EN.
- Defined: ovf is registered at the final-limb edge, alongside cout, as (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]), computed from the latched operands and the final top-limb add_sum. It is held like cout and cleared by reset.
- Not defined: the ovf port exists but is tied to 0, and no overflow logic is built.

Test Plan:
- Carry ripple: WORDS=4, a=0x0000_0000_0000_FFFF, b=0x1, cin=0, one start pulse → done in the cycle after edge 4. Required: sum=0x0000_0000_0001_0000, cout=0, busy high for exactly 4 cycles.
- Full-chain carry: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 → sum=0, cout=1, ovf=0. Required: add_cin per RUN cycle = 1,1,1,1.
- Signed overflow (macro defined): a=0x7FFF_FFFF_FFFF_FFFF, b=0x1, cin=0 → sum=0x8000_0000_0000_0000, cout=0, ovf=1. Without the macro, ovf=0.
- Busy rejection: start with a=0x1234, b=0x1; at edge 2 pulse start with a=0xFFFF, b=0xFFFF → only one done pulse. Required: sum=0x1235, busy never re-asserts without a new start in IDLE.
- Reset mid-operation: rst=1 at edge 2 of a RUN → busy=0, done=0, sum=0, cout=0. Then start with a=5, b=7 → sum=12 after the normal latency.
- Back-to-back: start held high for 10 cycles → a done pulse every 5 cycles, and the second result is correct with operands captured in its own start cycle.

Source files
------------

// File: rtl/mp_add_sequencer_if.sv
// Command and shared-adder signal bundle for mp_add_sequencer.
// slave = sequencer, master = command requester, adder = the external 16-bit adder.
interface mp_add_sequencer_if #(
    parameter int W     = 16,
    parameter int WORDS = 4
);
    logic                 start;
    logic [W*WORDS-1:0]   a;
    logic [W*WORDS-1:0]   b;
    logic                 cin;
    logic                 busy;
    logic                 done;
    logic [W*WORDS-1:0]   sum;
    logic                 cout;
    logic                 ovf;
    logic [W-1:0]         add_a;
    logic [W-1:0]         add_b;
    logic                 add_cin;
    logic [W-1:0]         add_sum;
    logic                 add_cout;

    modport slave (
        input  start, a, b, cin, add_sum, add_cout,
        output busy, done, sum, cout, ovf, add_a, add_b, add_cin
    );

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport adder (
        input  add_a, add_b, add_cin,
        output add_sum, add_cout
    );
endinterface

// File: rtl/mp_add_sequencer.sv
// Multi-precision adder sequencer: drives one shared W-bit adder over WORDS limbs, LSB first.
// Optional signed-overflow flag built only when MP_ADD_OVF_EN is defined.
module mp_add_sequencer #(
    parameter int W     = 16,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    mp_add_sequencer_if.slave  bus
);
    localparam int N  = W * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q,   idx_d;
    logic            carry_q, carry_d;
    logic [N-1:0]    a_q,     a_d;
    logic [N-1:0]    b_q,     b_d;
    logic            cin_q,   cin_d;
    logic [N-1:0]    sum_q,   sum_d;
    logic            cout_q,  cout_d;
    logic            busy_q,  busy_d;
    logic            done_q,  done_d;

    logic [W-1:0]    limb_a_s;
    logic [W-1:0]    limb_b_s;
    logic            limb_cin_s;

    // Constant-index limb mux keeps the select free of variable part-selects.
    function automatic logic [W-1:0] limb_of(input logic [N-1:0] vec, input logic [IW-1:0] idx);
        logic [W-1:0] res;
        res = {W{1'b0}};
        for (int i = 0; i < WORDS; i++) begin
            if (idx == IW'(i)) begin
                res = vec[i*W +: W];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Adder drive: current limb while running, quiet zeros when idle.
    always_comb begin
        limb_a_s   = {W{1'b0}};
        limb_b_s   = {W{1'b0}};
        limb_cin_s = 1'b0;
        if (state_q == RUN) begin
            limb_a_s   = limb_of(a_q, idx_q);
            limb_b_s   = limb_of(b_q, idx_q);
            limb_cin_s = (idx_q == {IW{1'b0}}) ? cin_q : carry_q;
        end else begin
            limb_a_s   = {W{1'b0}};
            limb_b_s   = {W{1'b0}};
            limb_cin_s = 1'b0;
        end
    end

    assign bus.add_a   = limb_a_s;
    assign bus.add_b   = limb_b_s;
    assign bus.add_cin = limb_cin_s;

    // Next-state and datapath update for the IDLE/RUN sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    cin_d   = bus.cin;
                    idx_d   = {IW{1'b0}};
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                for (int i = 0; i < WORDS; i++) begin
                    if (idx_q == IW'(i)) begin
                        sum_d[i*W +: W] = bus.add_sum;
                    end else begin
                        sum_d[i*W +: W] = sum_q[i*W +: W];
                    end
                end
                carry_d = bus.add_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = bus.add_cout;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    idx_d   = {IW{1'b0}};
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + {{(IW-1){1'b0}}, 1'b1};
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = {IW{1'b0}};
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= {IW{1'b0}};
            carry_q <= 1'b0;
            a_q     <= {N{1'b0}};
            b_q     <= {N{1'b0}};
            cin_q   <= 1'b0;
            sum_q   <= {N{1'b0}};
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

`ifdef MP_ADD_OVF_EN
    logic ovf_q, ovf_d;

    // Signed overflow: like-signed operands whose final top-limb sum flips sign.
    always_comb begin
        ovf_d = ovf_q;
        if ((state_q == RUN) && (idx_q == LAST_IDX)) begin
            ovf_d = (a_q[N-1] == b_q[N-1]) && (bus.add_sum[W-1] != a_q[N-1]);
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Overflow flag register, held until the next final limb.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Directed self-checking bench for mp_add_sequencer (W=16, WORDS=4) with a behavioural adder.
module tb_mp_add_sequencer;
    localparam int W     = 16;
    localparam int WORDS = 4;
    localparam int N     = W * WORDS;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    mp_add_sequencer_if #(.W(W), .WORDS(WORDS)) bus ();

    mp_add_sequencer #(.W(W), .WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Shared external adder: purely combinational.
    assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{W{1'b0}}, bus.add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents a one-cycle start; returns at the negedge after the accepting edge.
    task automatic start_op(input logic [N-1:0] av, input logic [N-1:0] bv, input logic cv);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        bus.cin   = cv;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Waits (bounded) for done, counting busy cycles and recording add_cin per RUN cycle.
    task automatic wait_done(output int busy_cnt, output logic [3:0] cins, output logic got);
        busy_cnt = 0;
        cins     = 4'b0000;
        got      = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (bus.busy === 1'b1) begin
                if (busy_cnt < 4) cins[busy_cnt] = bus.add_cin;
                busy_cnt++;
            end
            @(negedge clk);
        end
    endtask

    int          bc;
    logic [3:0]  cins;
    logic        got;
    int          n_busy;
    int          n_done;
    int          done_k [2];
    logic [N-1:0] done_sum [2];
    logic        exp_ovf;

    initial begin
        compared   = 0;
        mismatched = 0;
        bus.start  = 1'b0;
        bus.a      = {N{1'b0}};
        bus.b      = {N{1'b0}};
        bus.cin    = 1'b0;
        rst        = 1'b1;
        repeat (3) @(negedge clk);

        check("reset_busy", {63'd0, bus.busy}, 64'd0);
        check("reset_done", {63'd0, bus.done}, 64'd0);
        check("reset_sum",  bus.sum, 64'd0);
        check("reset_cout", {63'd0, bus.cout}, 64'd0);
        check("reset_ovf",  {63'd0, bus.ovf}, 64'd0);
        check("reset_add_a", {48'd0, bus.add_a}, 64'd0);
        rst = 1'b0;

        // Carry ripple across limb 0 into limb 1.
        start_op(64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0);
        wait_done(bc, cins, got);
        check("ripple_done", {63'd0, got}, 64'd1);
        check("ripple_busy_cycles", 64'(bc), 64'd4);
        check("ripple_busy_low", {63'd0, bus.busy}, 64'd0);
        check("ripple_sum", bus.sum, 64'h0000_0000_0001_0000);
        check("ripple_cout", {63'd0, bus.cout}, 64'd0);
        check("ripple_cins", {60'd0, cins}, 64'b0010);
        @(negedge clk);
        check("ripple_done_pulse", {63'd0, bus.done}, 64'd0);
        check("ripple_sum_held", bus.sum, 64'h0000_0000_0001_0000);

        // Carry through every limb.
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
        wait_done(bc, cins, got);
        check("chain_done", {63'd0, got}, 64'd1);
        check("chain_sum", bus.sum, 64'h0);
        check("chain_cout", {63'd0, bus.cout}, 64'd1);
        check("chain_ovf", {63'd0, bus.ovf}, 64'd0);
        check("chain_cins", {60'd0, cins}, 64'b1111);

        // Signed overflow into the sign bit.
`ifdef MP_ADD_OVF_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        wait_done(bc, cins, got);
        check("ovf_done", {63'd0, got}, 64'd1);
        check("ovf_sum", bus.sum, 64'h8000_0000_0000_0000);
        check("ovf_cout", {63'd0, bus.cout}, 64'd0);
        check("ovf_flag", {63'd0, bus.ovf}, {63'd0, exp_ovf});

        // Start while busy is ignored.
        start_op(64'h1234, 64'h1, 1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 64'hFFFF;
        bus.b     = 64'hFFFF;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(bc, cins, got);
        check("busyrej_done", {63'd0, got}, 64'd1);
        check("busyrej_sum", bus.sum, 64'h1235);
        check("busyrej_cout", {63'd0, bus.cout}, 64'd0);
        n_busy = 0;
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) n_busy++;
            if (bus.done === 1'b1) n_done++;
        end
        check("busyrej_no_rebusy", 64'(n_busy), 64'd0);
        check("busyrej_no_redone", 64'(n_done), 64'd0);

        // Reset in the middle of a run.
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", {63'd0, bus.busy}, 64'd0);
        check("midrst_done", {63'd0, bus.done}, 64'd0);
        check("midrst_sum",  bus.sum, 64'd0);
        check("midrst_cout", {63'd0, bus.cout}, 64'd0);
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) n_done++;
        end
        check("midrst_quiet", 64'(n_done), 64'd0);
        start_op(64'd5, 64'd7, 1'b0);
        wait_done(bc, cins, got);
        check("postrst_done", {63'd0, got}, 64'd1);
        check("postrst_busy_cycles", 64'(bc), 64'd4);
        check("postrst_sum", bus.sum, 64'd12);

        // Start held high for ten cycles with operands changing each cycle.
        @(negedge clk);
        n_done = 0;
        for (int k = 0; k < 10; k++) begin
            bus.start = 1'b1;
            bus.a     = 64'h0000_FFFF_0000_FFFF + 64'(k);
            bus.b     = 64'h0000_0001_0000_0001;
            bus.cin   = 1'b0;
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (n_done < 2) begin
                    done_k[n_done]   = k;
                    done_sum[n_done] = bus.sum;
                end
                n_done++;
            end
        end
        bus.start = 1'b0;
        check("b2b_done_count", 64'(n_done), 64'd2);
        check("b2b_first_at", 64'(done_k[0]), 64'd4);
        check("b2b_second_at", 64'(done_k[1]), 64'd9);
        check("b2b_first_sum", done_sum[0], 64'h0001_0000_0001_0000);
        check("b2b_second_sum", done_sum[1], 64'h0001_0000_0001_0005);
        repeat (3) @(negedge clk);
        check("b2b_idle_after", {63'd0, bus.busy}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
